pwm_ramp: RTL and testbench

Slew-rate limiter that sits directly upstream of the `pwm` block and drives its 8-bit `pwm_width` input. A new duty-cycle target is accepted with a one-cycle `load` strobe. The output width then moves toward that target by a fixed step once every `TICK_DIV` clocks, so the PWM output soft-starts and soft-stops instead of jumping. `busy` and `done` report ramp progress to the controlling logic.

---
 rtl/pwm_ramp.sv | 96 +++++++++
 tb/tb_pwm_ramp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp.sv
// Slew-rate limiter feeding pwm.pwm_width: moves toward a latched target by STEP once every TICK_DIV clocks.
// Optional target ceiling (MAX_WIDTH) is enabled by defining PWM_RAMP_LIMIT_EN.
module pwm_ramp #(
  parameter int         STEP      = 4,
  parameter int         TICK_DIV  = 256,
  parameter logic [7:0] MAX_WIDTH = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target,
  input  logic       load,
  output logic [7:0] pwm_width,
  output logic       busy,
  output logic       done
);

`ifdef PWM_RAMP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state;
  logic [7:0]       tgt_q;
  logic [CNT_W-1:0] cnt;

  function automatic logic [7:0] clamp_target(input logic [7:0] t);
    return (LIMIT_EN && (t > MAX_WIDTH)) ? MAX_WIDTH : t;
  endfunction

  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] wa, wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

  // Only called when the distance exceeds STEP, so the result cannot wrap or overshoot.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    return (tgt > cur) ? (cur + 8'(STEP)) : (cur - 8'(STEP));
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pwm_width <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_q     <= 8'd0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            tgt_q <= clamp_target(target);
            if (clamp_target(target) != pwm_width) begin
              state <= RAMP;
              busy  <= 1'b1;
              cnt   <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RAMP: begin
          // A load on a tick edge only replaces tgt_q; this tick still uses the old target.
          if (load) tgt_q <= clamp_target(target);
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (abs_diff(tgt_q, pwm_width) <= 9'(STEP)) begin
              pwm_width <= tgt_q;
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              pwm_width <= step_toward(pwm_width, tgt_q);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp.sv
// Randomized bench for pwm_ramp: directed ramp scenarios plus random loads/resets,
// checked every cycle against an event-time reference model.
module tb_pwm_ramp;
  localparam int STEP     = 4;
  localparam int TICK_DIV = 256;
  localparam int MAXW     = 8'hF0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] target = 8'd0;
  logic       load = 1'b0;
  logic [7:0] pwm_width;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  pwm_ramp #(.STEP(STEP), .TICK_DIV(TICK_DIV), .MAX_WIDTH(8'hF0)) dut (
    .clk(clk), .rst(rst), .target(target), .load(load),
    .pwm_width(pwm_width), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: ramp progress kept as absolute cycle numbers of the next update.
  longint cyc = 0;
  longint next_upd = 0;
  int     m_w = 0, m_t = 0;
  bit     m_busy = 0, m_done = 0;

  function automatic int latch_val(input int t);
`ifdef PWM_RAMP_LIMIT_EN
    return (t > MAXW) ? MAXW : t;
`else
    return t;
`endif
  endfunction

  always @(posedge clk) begin
    bit was_busy;
    int d;
    cyc++;
    if (!rst) begin
      m_w = 0; m_t = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done   = 0;
      was_busy = m_busy;
      if (m_busy && cyc == next_upd) begin
        d = m_t - m_w;
        if (d <= STEP && d >= -STEP) m_w = m_t;
        else m_w = m_w + ((d > 0) ? STEP : -STEP);
        if (m_w == m_t) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          next_upd = cyc + TICK_DIV;
        end
      end
      if (load) begin
        m_t = latch_val(int'(target));
        if (!was_busy) begin
          if (m_t == m_w) m_done = 1;
          else begin
            m_busy   = 1;
            next_upd = cyc + TICK_DIV;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  int done_cnt = 0;
  int min_w = 255, max_w = 0;

  task automatic cyc1();
    @(negedge clk);
    chk("out", {22'd0, pwm_width, busy, done}, {22'd0, 8'(m_w), m_busy, m_done});
    if (done) done_cnt++;
    if (int'(pwm_width) < min_w) min_w = int'(pwm_width);
    if (int'(pwm_width) > max_w) max_w = int'(pwm_width);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc1();
  endtask

  task automatic do_load(input logic [7:0] t);
    target = t;
    load   = 1'b1;
    cyc1();
    load   = 1'b0;
    target = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc1();
      n++;
    end
    if (busy) chk("idle_timeout", 32'(n), 32'(budget + 1));
  endtask

  task automatic reset_stats();
    done_cnt = 0;
    min_w = 255;
    max_w = 0;
  endtask

  initial begin
    // 1: reset held with load toggling
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load   = i[0];
      target = 8'($urandom);
      cyc1();
      chk("rst_out", {22'd0, pwm_width, busy, done}, 32'd0);
    end
    load = 1'b0;
    rst  = 1'b1;
    run(3);
    chk("rel_out", {22'd0, pwm_width, busy, done}, 32'd0);

    // 2: ramp up 0 -> 0x80
    reset_stats();
    do_load(8'h80);
    chk("up_busy", 32'(busy), 32'd1);
    wait_idle(9000);
    chk("up_width", 32'(pwm_width), 32'h80);
    chk("up_done_cnt", 32'(done_cnt), 32'd1);
    chk("up_done_edge", 32'(done), 32'd1);
    cyc1();
    chk("up_done_clr", 32'(done), 32'd0);

    // 3: ramp down 0x80 -> 0x22 with final snap
    reset_stats();
    do_load(8'h22);
    wait_idle(7000);
    chk("dn_width", 32'(pwm_width), 32'h22);
    chk("dn_min", 32'(min_w), 32'h22);
    chk("dn_done_cnt", 32'(done_cnt), 32'd1);

    // 4: retarget mid-ramp
    do_load(8'h40);
    wait_idle(3000);
    reset_stats();
    do_load(8'hC0);
    run(3 * TICK_DIV);
    chk("rt_mid", 32'(pwm_width), 32'h4C);
    do_load(8'h44);
    wait_idle(1000);
    chk("rt_width", 32'(pwm_width), 32'h44);
    chk("rt_max", 32'(max_w), 32'h4C);

    // 5: same-target load, then reset mid-ramp
    reset_stats();
    do_load(8'h44);
    chk("eq_done", 32'(done), 32'd1);
    chk("eq_busy", 32'(busy), 32'd0);
    chk("eq_width", 32'(pwm_width), 32'h44);
    cyc1();
    chk("eq_done_clr", 32'(done), 32'd0);
    do_load(8'hC0);
    run(600);
    rst = 1'b0;
    cyc1();
    chk("mid_rst", {22'd0, pwm_width, busy, done}, 32'd0);
    rst = 1'b1;
    run(2);

    // 6: full-scale target
    do_load(8'hFF);
    wait_idle(20000);
`ifdef PWM_RAMP_LIMIT_EN
    chk("max_width", 32'(pwm_width), 32'hF0);
`else
    chk("max_width", 32'(pwm_width), 32'hFF);
`endif

    // Random loads, retargets (some on tick edges) and occasional resets
    for (int k = 0; k < 40; k++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? (TICK_DIV - 1) : int'($urandom_range(1, 600));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b0;
        cyc1();
        rst = 1'b1;
      end
      do_load(8'($urandom));
      run(gap);
    end
    wait_idle(20000);
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
